// File: rtl/jamma_pkg.sv
// ---------------------------------------------------------------------------
// jamma_pkg
// Shared definitions for the JAMMA joystick scanner.
//   - JAMMA bit positions inside one player's input byte
//   - JOY_RELEASED : the all-released (all ones, active low) byte
//   - clog2        : constant-evaluable ceil(log2()) for sizing counters
// ---------------------------------------------------------------------------
package jamma_pkg;

    localparam int UP         = 0;
    localparam int DOWN       = 1;
    localparam int LEFT       = 2;
    localparam int RIGHT      = 3;
    localparam int B1         = 4;
    localparam int B2         = 5;
    localparam int COIN_START = 6;
    localparam int PLAYER     = 7;

    localparam logic [7:0] JOY_RELEASED = 8'hFF;

    // Returns the number of bits needed to hold values 0..value-1.
    // clog2(1) = 0, so callers that need a real register clamp to 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jamma_joy_scanner_debounce.sv
// ---------------------------------------------------------------------------
// joy_debounce
// Scan-based debouncer for one player's input byte. Only evaluates when
// sample_en_i is high (once per frame, in that player's slot). The output
// follows raw_i only after DEBOUNCE further identical samples; DEBOUNCE = 0
// makes it a registered pass-through.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   sample_en_i   : this player's sample strobe
//   raw_i         : merged raw sample (active low)
//   out_o         : debounced state (active low, resets to released)
// ---------------------------------------------------------------------------
module joy_debounce
    import jamma_pkg::*;
#(
    parameter int JOY_W    = 8,
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en_i,
    input  logic [JOY_W-1:0] raw_i,
    output logic [JOY_W-1:0] out_o
);

    localparam int CNT_W = (clog2(DEBOUNCE + 1) < 1) ? 1 : clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [JOY_W-1:0] last_raw_q, last_raw_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [JOY_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_step;

    // A changed sample restarts the stability count; an identical one
    // advances it, saturating at CNT_MAX. The output is (re)loaded whenever
    // the resulting count equals CNT_MAX, which also covers DEBOUNCE = 0
    // where the count is always zero.
    always_comb begin
        last_raw_d   = last_raw_q;
        stable_cnt_d = stable_cnt_q;
        out_d        = out_q;
        cnt_step     = stable_cnt_q;
        if (raw_i != last_raw_q) begin
            cnt_step = '0;
        end else if (stable_cnt_q != CNT_MAX) begin
            cnt_step = stable_cnt_q + 1'b1;
        end
        if (sample_en_i) begin
            last_raw_d   = raw_i;
            stable_cnt_d = cnt_step;
            if (cnt_step == CNT_MAX) begin
                out_d = raw_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_raw_q   <= '1;
            stable_cnt_q <= '0;
            out_q        <= '1;
        end else begin
            last_raw_q   <= last_raw_d;
            stable_cnt_q <= stable_cnt_d;
            out_q        <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// ---------------------------------------------------------------------------
// jamma_joy_scanner
// Time-multiplexed JAMMA joystick scanner. Each player owns a slot of
// SCAN_DIV cycles; jselect selects that player on the external mux, the
// shared bus is synchronised, sampled SETTLE cycles into the slot, and fed
// to that player's debouncer. Player 0 is merged with the onboard joystick.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   joy_in       : shared connector bus (active low, asynchronous)
//   local_joy    : onboard joystick (active low), ANDed into player 0
//   jselect      : player select to the external multiplexer
//   joy_out      : debounced state, player p at [p*JOY_W +: JOY_W]
//   frame_done   : one-cycle pulse with the last player's update
// ---------------------------------------------------------------------------
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int JOY_W       = 8,
    parameter int SCAN_DIV    = 64,
    parameter int SETTLE      = 8,
    parameter int DEBOUNCE    = 2,
    localparam int SEL_W      = (clog2(NUM_PLAYERS) < 1) ? 1 : clog2(NUM_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [JOY_W-1:0]             joy_in,
    input  logic [JOY_W-1:0]             local_joy,
    output logic [SEL_W-1:0]             jselect,
    output logic [NUM_PLAYERS*JOY_W-1:0] joy_out,
    output logic                         frame_done
);

    localparam int CNT_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SAMPLE_SLOT = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] LAST_PLAYER = SEL_W'(NUM_PLAYERS - 1);

    logic [JOY_W-1:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [SEL_W-1:0]       player_idx_q, player_idx_d;
    logic [SEL_W-1:0]       jselect_q, jselect_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sample_now;
    logic [JOY_W-1:0]       raw;
    logic [NUM_PLAYERS-1:0] sample_en;

    // Slot/player sequencing. jselect is loaded only on the slot boundary,
    // so it is stable across the whole settle window and sample point.
    // frame_done is registered so it lines up with the registered update
    // of the last player's output.
    always_comb begin
        slot_cnt_d   = slot_cnt_q + 1'b1;
        player_idx_d = player_idx_q;
        jselect_d    = jselect_q;
        sample_now   = (slot_cnt_q == SAMPLE_SLOT);
        raw          = sync2_q;
        sample_en    = '0;
        if (slot_cnt_q == LAST_SLOT) begin
            slot_cnt_d   = '0;
            player_idx_d = (player_idx_q == LAST_PLAYER) ? '0 : player_idx_q + 1'b1;
            jselect_d    = player_idx_d;
        end
        if (player_idx_q == '0) begin
            raw = sync2_q & local_joy;
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            sample_en[p] = sample_now && (player_idx_q == SEL_W'(p));
        end
        frame_done_d = sample_now && (player_idx_q == LAST_PLAYER);
    end

    // Synchroniser resets to released so nothing looks pressed after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            slot_cnt_q   <= '0;
            player_idx_q <= '0;
            jselect_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= joy_in;
            sync2_q      <= sync1_q;
            slot_cnt_q   <= slot_cnt_d;
            player_idx_q <= player_idx_d;
            jselect_q    <= jselect_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        joy_debounce #(
            .JOY_W    (JOY_W),
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_en_i (sample_en[p]),
            .raw_i       (raw),
            .out_o       (joy_out[p*JOY_W +: JOY_W])
        );
    end

    assign jselect    = jselect_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// ---------------------------------------------------------------------------
// tb_jamma_joy_scanner
// Three scanner configurations side by side on one clock:
//   A : 2 players, SCAN_DIV 64, SETTLE 8, DEBOUNCE 2
//   B : same as A with DEBOUNCE 0, fed from the same mux patterns
//   C : 4 players, SCAN_DIV 16, SETTLE 4, DEBOUNCE 2
// Each DUT's joy_in comes from a model of the external mux indexed by that
// DUT's own jselect. Expected values are queued when stimulus is applied
// and popped when the corresponding DUT output is examined.
// ---------------------------------------------------------------------------
module tb_jamma_joy_scanner;
    import jamma_pkg::*;

    logic        clk;
    logic        reset_n;

    logic [7:0]  patA [0:1];
    logic [7:0]  patC [0:3];
    logic [7:0]  joyInA, joyInB, joyInC;
    logic [7:0]  localA, localB, localC;
    logic        jselA, jselB;
    logic [1:0]  jselC;
    logic [15:0] joyOutA, joyOutB;
    logic [31:0] joyOutC;
    logic        frameDoneA, frameDoneB, frameDoneC;

    int          total;
    int          bad;
    int          cyc;
    int          seen;
    logic [1:0]  prevSel;

    logic [31:0] expQ [$];
    string       tagQ [$];

    // External multiplexer models
    assign joyInA = patA[jselA];
    assign joyInB = patA[jselB];
    assign joyInC = patC[jselC];

    jamma_joy_scanner #(
        .NUM_PLAYERS (2), .JOY_W (8), .SCAN_DIV (64), .SETTLE (8), .DEBOUNCE (2)
    ) dutA (
        .clk (clk), .reset_n (reset_n), .joy_in (joyInA), .local_joy (localA),
        .jselect (jselA), .joy_out (joyOutA), .frame_done (frameDoneA)
    );

    jamma_joy_scanner #(
        .NUM_PLAYERS (2), .JOY_W (8), .SCAN_DIV (64), .SETTLE (8), .DEBOUNCE (0)
    ) dutB (
        .clk (clk), .reset_n (reset_n), .joy_in (joyInB), .local_joy (localB),
        .jselect (jselB), .joy_out (joyOutB), .frame_done (frameDoneB)
    );

    jamma_joy_scanner #(
        .NUM_PLAYERS (4), .JOY_W (8), .SCAN_DIV (16), .SETTLE (4), .DEBOUNCE (2)
    ) dutC (
        .clk (clk), .reset_n (reset_n), .joy_in (joyInC), .local_joy (localC),
        .jselect (jselC), .joy_out (joyOutC), .frame_done (frameDoneC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input string tag, input logic [31:0] expected);
        tagQ.push_back(tag);
        expQ.push_back(expected);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL noExpectation observed=%h expected=<none>", observed);
        end else begin
            tag      = tagQ.pop_front();
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    task automatic waitFramesA(input int n);
        int got;
        int budget;
        got    = 0;
        budget = 0;
        while (got < n && budget < n * 128 + 300) begin
            @(negedge clk);
            budget++;
            if (frameDoneA) got++;
        end
        if (got < n) begin
            total++;
            bad++;
            $error("[TB] FAIL timeoutFramesA observed=%0d expected=%0d", got, n);
        end
    endtask

    task automatic waitFramesC(input int n);
        int got;
        int budget;
        got    = 0;
        budget = 0;
        while (got < n && budget < n * 64 + 100) begin
            @(negedge clk);
            budget++;
            if (frameDoneC) got++;
        end
        if (got < n) begin
            total++;
            bad++;
            $error("[TB] FAIL timeoutFramesC observed=%0d expected=%0d", got, n);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        patA[0] = JOY_RELEASED;
        patA[1] = JOY_RELEASED;
        patC[0] = 8'hE1;
        patC[1] = 8'hE2;
        patC[2] = 8'hE4;
        patC[3] = 8'hE8;
        localA  = JOY_RELEASED;
        localB  = JOY_RELEASED;
        localC  = JOY_RELEASED;

        // Reset values
        repeat (3) @(negedge clk);
        applyStimulus("rstJoyA", 32'h0000FFFF);
        checkOutput(32'(joyOutA));
        applyStimulus("rstSelA", 32'h0);
        checkOutput(32'(jselA));
        applyStimulus("rstFrameA", 32'h0);
        checkOutput(32'(frameDoneA));
        applyStimulus("rstJoyC", 32'hFFFFFFFF);
        checkOutput(joyOutC);
        reset_n = 1'b1;

        // Four players: each pattern lands in its own lane after 3 frames
        applyStimulus("lanesC", 32'hE8E4E2E1);
        waitFramesC(3);
        checkOutput(joyOutC);

        // Four players: frame period
        applyStimulus("periodC", 32'd64);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frameDoneC && cyc < 200);
        checkOutput(32'(cyc));

        // Four players: select sequence 0,1,2,3,0
        applyStimulus("selSeq0", 32'd0);
        applyStimulus("selSeq1", 32'd1);
        applyStimulus("selSeq2", 32'd2);
        applyStimulus("selSeq3", 32'd3);
        applyStimulus("selSeq4", 32'd0);
        prevSel = jselC;
        seen    = 0;
        cyc     = 0;
        while (seen < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (jselC != prevSel) begin
                prevSel = jselC;
                seen++;
                checkOutput(32'(jselC));
            end
        end

        // Idle: released everywhere, select period and frame period
        waitFramesA(1);
        applyStimulus("idleJoyA", 32'h0000FFFF);
        checkOutput(32'(joyOutA));
        applyStimulus("framePeriodA", 32'd128);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frameDoneA && cyc < 400);
        checkOutput(32'(cyc));
        prevSel = {1'b0, jselA};
        cyc     = 0;
        while (jselA == prevSel[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        applyStimulus("selPeriodA", 32'd64);
        prevSel = {1'b0, jselA};
        cyc     = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (jselA == prevSel[0] && cyc < 200);
        checkOutput(32'(cyc));

        // Player isolation: only player 0 pressed
        waitFramesA(1);
        patA[0] = 8'hFE;
        applyStimulus("isoTwoFramesA", 32'h0000FFFF);
        applyStimulus("isoTwoFramesB", 32'h0000FFFE);
        waitFramesA(2);
        checkOutput(32'(joyOutA));
        checkOutput(32'(joyOutB));
        applyStimulus("isoThreeFramesA", 32'h0000FFFE);
        waitFramesA(1);
        checkOutput(32'(joyOutA));

        // Local merge into player 0
        patA[0] = JOY_RELEASED;
        localA  = 8'hF7;
        applyStimulus("mergeTwoFramesA", 32'h0000FFFE);
        applyStimulus("mergeTwoFramesB", 32'h0000FFFF);
        waitFramesA(2);
        checkOutput(32'(joyOutA));
        checkOutput(32'(joyOutB));
        applyStimulus("mergeThreeFramesA", 32'h0000FFF7);
        waitFramesA(1);
        checkOutput(32'(joyOutA));

        // Single-sample glitch on player 1 bit 4
        patA[1] = 8'hEF;
        applyStimulus("glitchA", 32'h0000FFF7);
        applyStimulus("glitchPassB", 32'h0000EFFF);
        waitFramesA(1);
        checkOutput(32'(joyOutA));
        checkOutput(32'(joyOutB));
        patA[1] = JOY_RELEASED;
        applyStimulus("glitchGoneB", 32'h0000FFFF);
        waitFramesA(1);
        checkOutput(32'(joyOutB));
        applyStimulus("glitchLaterA", 32'h0000FFF7);
        waitFramesA(2);
        checkOutput(32'(joyOutA));

        // Reset during player 1 settle window
        cyc = 0;
        while (jselA != 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        patA[0] = 8'hFE;
        #1;
        applyStimulus("midRstJoyA", 32'h0000FFFF);
        checkOutput(32'(joyOutA));
        applyStimulus("midRstSelA", 32'h0);
        checkOutput(32'(jselA));
        applyStimulus("midRstFrameA", 32'h0);
        checkOutput(32'(frameDoneA));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("firstSampleCycle", 32'd9);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (joyOutB[7:0] != 8'hFE && cyc < 200);
        checkOutput(32'(cyc));
        applyStimulus("firstSampleJoyB", 32'h0000FFFE);
        checkOutput(32'(joyOutB));
        applyStimulus("firstSampleSel", 32'h0);
        checkOutput(32'(jselB));

        // Any expectation never matched by an output is a failure
        while (expQ.size() > 0) begin
            total++;
            bad++;
            $error("[TB] FAIL unmatched %s observed=<none> expected=%h",
                   tagQ.pop_front(), expQ.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jamma_joy_scanner.md
# jamma_joy_scanner

Time-multiplexed JAMMA joystick scanner: drives a player-select line to an external board, lets the shared bus settle, samples each player's active-low input byte and presents debounced per-player state to the arcade core. Parametrised successor of the fixed 2-player toggle splitter in the arcade top levels. Adds N players, configurable width, settle and slot timing, an onboard-joystick merge, scan-based debounce and a frame strobe. Sits between the JAMMA connector pins and the core's joystick/player/coin inputs.

## Interface
- NUM_PLAYERS, 2: players scanned, 2..4.
- JOY_W, 8: bits per player.
- SCAN_DIV, 64: clk cycles per player slot, 4..65535.
- SETTLE, 8: cycles after a select change before sampling, 1..SCAN_DIV-2.
- DEBOUNCE, 2: consecutive identical scans needed before an output changes; 0 means pass-through.
- SEL_W, derived: max(1, clog2(NUM_PLAYERS)).

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- joy_in  in  JOY_W  shared connector bus, active low, asynchronous to clk.
- local_joy  in  JOY_W  onboard joystick, active low, ANDed into player 0.
- jselect  out  SEL_W  player select to the external multiplexer.
- joy_out  out  NUM_PLAYERS*JOY_W  debounced state, player p in bits [p*JOY_W +: JOY_W], active low.
- frame_done  out  1  one-cycle pulse after the last player's sample is processed.

## Operation
- Synchroniser: joy_in passes through a 2-flop synchroniser. Sampling uses the synchronised value.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1.
  - player_idx counts 0..NUM_PLAYERS-1 and wraps to 0.
- Slot boundary: at slot_cnt == SCAN_DIV-1, player_idx advances and jselect <= next player_idx, registered.
- Sample point: slot_cnt == SETTLE. At that point raw = sync_joy, ANDed with local_joy when player_idx == 0.
- Debounce, per player p:
  - Hold last_raw[p] and stable_cnt[p], width clog2(DEBOUNCE+1).
  - If raw != last_raw[p]: last_raw[p] <= raw, stable_cnt[p] <= 0.
  - Else if stable_cnt[p] < DEBOUNCE: stable_cnt[p]++.
  - When the resulting count reaches DEBOUNCE, joy_out[p] <= raw. The count saturates there.
  - DEBOUNCE=0: joy_out[p] <= raw on every sample.
- frame_done: pulses on the cycle joy_out for player NUM_PLAYERS-1 is updated, or would be updated, by its sample.
- Players are updated only in their own slot. Other players' outputs hold.
- The block has no bus handshake. joy_out is level-valid at all times.

## Timing
- Reset values:
  - jselect = 0, slot_cnt = 0, player_idx = 0.
  - joy_out = all ones (released), last_raw = all ones, stable_cnt = 0.
  - frame_done = 0, synchroniser = all ones.
- Reset asserted mid-scan clears everything immediately. The scan restarts at player 0, slot_cnt 0, on the first clk after reset_n rises.
- Input latency: joy_in change to sampled value is 2 cycles of synchroniser, plus the wait to the next sample point of that player.
- Sample to joy_out update: 1 cycle. frame_done is coincident with the last player's update cycle.
- Frame period: NUM_PLAYERS*SCAN_DIV cycles.
- Worst-case press latency: (DEBOUNCE+1)*frame period + SETTLE + 3 cycles.
- A single-scan glitch never reaches joy_out when DEBOUNCE >= 1.
- jselect changes exactly once per slot, at the boundary cycle. It never changes inside the settle window.

## Structure
- Shared package jamma_pkg holds:
  - JAMMA bit positions: UP=0, DOWN=1, LEFT=2, RIGHT=3, B1=4, B2=5, COIN_START=6, PLAYER=7.
  - JOY_RELEASED all-ones constant.
  - clog2 helper.
- One natural sub-module: joy_debounce, a per-player last_raw/stable_cnt/out register with a sample-enable input. It is instantiated NUM_PLAYERS times via generate.
- Slot and player counters and the synchroniser live in the top.

## Test plan
- Reset then idle: NUM_PLAYERS=2, joy_in=8'hFF. Required: joy_out = 16'hFFFF, jselect toggles every 64 cycles, frame_done pulses every 128 cycles.
- Player isolation: external mux model drives 8'hFE when jselect=0 and 8'hFF otherwise, DEBOUNCE=2. Required: joy_out[7:0] = 8'hFE after 3 frames, joy_out[15:8] stays 8'hFF.
- Glitch rejection: DEBOUNCE=2, player 1 bit 4 low for exactly one sample. Required: joy_out unchanged. With DEBOUNCE=0, same stimulus: bit 12 goes low for one frame.
- Local merge: local_joy = 8'hF7, joy_in = 8'hFF. Required: player 0 = 8'hF7 after debounce, player 1 = 8'hFF.
- 4-player wrap: NUM_PLAYERS=4, SCAN_DIV=16, SETTLE=4. Required:
  - jselect sequence 0,1,2,3,0.
  - Each player's distinct pattern (8'hE1, E2, E4, E8) lands in its own lane.
  - frame_done period = 64 cycles.
- Reset mid-operation: assert reset_n low during player 1 settle with outputs non-idle. Required: joy_out = all ones and jselect = 0 immediately. The first sample after release is player 0 at cycle SETTLE.
